hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have the following ports, clock and reset first:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_id_rs1_raddr, i_id_rs2_raddr  in  5  ID-stage source registers
- i_id_rs1_used, i_id_rs2_used  in  1  ID instruction reads rs1/rs2
- i_ex_rd_waddr  in  5  EX-stage destination register
- i_ex_rd_wen, i_ex_mem_read, i_ex_vld  in  1  EX-stage write-enable, load and valid
- i_mem_rd_waddr  in  5  MEM-stage (EX/MEM register) destination register
- i_mem_rd_wen, i_mem_mem_read, i_mem_vld  in  1  MEM-stage write-enable, load and valid
- i_wb_rd_waddr  in  5  WB-stage destination register
- i_wb_rd_wen, i_wb_vld  in  1  WB-stage write-enable and valid
- i_branch_taken  in  1  branch/jump redirect resolved in EX
- i_dmem_req, i_dmem_ack  in  1  data-memory request and completion handshake
- o_stall_if, o_stall_id, o_stall_ex, o_stall_mem  out  1  hold the pipeline register
- o_flush_id, o_flush_ex  out  1  force valid=0 into IF/ID and ID/EX
- o_fwd_a, o_fwd_b  out  2  operand forward select: 00 = regfile, 01 = EX/MEM result, 10 = WB data
- o_state  out  2  FSM state
- o_stall_cnt  out  16  stall-cycle performance counter

Function
REQ-002 SHALL use the FSM states RUN=00, LDUSE=01, MWAIT=10, FLUSH=11.
REQ-003 SHALL compute forwarding combinationally, with EX/MEM taking priority over WB.
REQ-004 SHALL set o_fwd_a=01 when i_mem_vld, i_mem_rd_wen, !i_mem_mem_read, i_mem_rd_waddr!=0 and i_mem_rd_waddr==i_id_rs1_raddr.
REQ-005 SHALL otherwise set o_fwd_a=10 when i_wb_vld, i_wb_rd_wen, i_wb_rd_waddr!=0 and i_wb_rd_waddr==i_id_rs1_raddr; otherwise o_fwd_a=00.
REQ-006 SHALL derive o_fwd_b identically using i_id_rs2_raddr.
REQ-007 SHALL detect load-use when i_ex_vld, i_ex_mem_read, i_ex_rd_waddr!=0, and the EX rd matches a used ID source register.
REQ-008 SHALL detect a memory wait when i_dmem_req && !i_dmem_ack.
REQ-009 SHALL apply event priority per cycle: memory wait > branch taken > load-use.
REQ-010 Memory wait (any state): SHALL assert all four stalls and no flush; the FSM enters MWAIT.
REQ-011 SHALL stay in MWAIT while the wait condition holds; the ack cycle SHALL leave all stalls deasserted and return the FSM to RUN.
REQ-012 SHALL ignore i_branch_taken during MWAIT; it SHALL be re-evaluated on the ack cycle, since EX is held stable.
REQ-013 Branch taken: SHALL assert o_flush_id and o_flush_ex for that cycle with no stall, suppressing load-use, and the FSM enters FLUSH.
REQ-014 FLUSH SHALL last exactly 1 cycle, then return to RUN unless a new event occurs.
REQ-015 Load-use: SHALL assert o_stall_if, o_stall_id and o_flush_ex for 1 cycle, and the FSM enters LDUSE.
REQ-016 LDUSE SHALL return to RUN next cycle; a repeated load-use in that cycle SHALL re-stall.
REQ-017 Outputs SHALL be combinational from inputs and the current state; only state and counter are registered.
REQ-018 o_stall_cnt SHALL increment by 1 in every cycle with o_stall_if=1.
REQ-019 o_stall_cnt SHALL saturate at 16'hFFFF and never wrap.
REQ-020 Register x0 SHALL never cause a forward or a stall.

Reset
REQ-021 Under i_rst: state=RUN and o_stall_cnt=0.
REQ-022 Under i_rst: all stall, flush and forward outputs SHALL be 0, regardless of other inputs.
REQ-023 Reset mid-MWAIT or mid-FLUSH SHALL abort the operation on the next clock, with no pending event retained.

Structure
REQ-024 A shared package SHALL hold the state encoding, the forward-select constants (FWD_RF, FWD_EXMEM, FWD_WB) and the counter width.
REQ-025 A sub-module fwd_sel SHALL provide single-operand forward selection, instantiated twice.
REQ-026 The block SHALL contain no other sub-modules.

Verification
REQ-027 Bench SHALL drive EX/MEM add x5 and ID rs1=x5 -> o_fwd_a=01; with WB also writing x5 -> still 01; with only WB writing x5 -> 10.
REQ-028 Bench SHALL drive EX lw x7 and ID rs2=x7, used -> one cycle of stall_if/id=1 and flush_ex=1, state LDUSE then RUN, o_stall_cnt=1.
REQ-029 Bench SHALL drive the same load-use with i_branch_taken=1 -> flush_id=flush_ex=1, stall_if=0, state FLUSH for 1 cycle.
REQ-030 Bench SHALL drive i_dmem_req=1 with ack low for 3 cycles plus i_branch_taken=1 -> all stalls=1 and no flush for 3 cycles; on the ack cycle stalls=0 and flushes=1.
REQ-031 Bench SHALL drive x0 as both EX load dest and WB dest with ID rs1=x0 -> fwd=00 and no stall.
REQ-032 Bench SHALL preload a near-saturated counter with continuous stalls -> o_stall_cnt holds at FFFF; asserting i_rst mid-MWAIT -> state RUN, counter 0 next cycle.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings and widths for the pipeline hazard controller.
package hazard_ctrl_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned FWD_W  = 2;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_LDUSE = 2'b01,
        ST_MWAIT = 2'b10,
        ST_FLUSH = 2'b11
    } state_e;

    localparam logic [FWD_W-1:0] FWD_RF    = 2'b00;
    localparam logic [FWD_W-1:0] FWD_EXMEM = 2'b01;
    localparam logic [FWD_W-1:0] FWD_WB    = 2'b10;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Single-operand forwarding select; EX/MEM result wins over WB data.
module fwd_sel
    import hazard_ctrl_pkg::*;
(
    input  logic [REG_AW-1:0] i_src_raddr,
    input  logic              i_mem_vld,
    input  logic              i_mem_rd_wen,
    input  logic              i_mem_mem_read,
    input  logic [REG_AW-1:0] i_mem_rd_waddr,
    input  logic              i_wb_vld,
    input  logic              i_wb_rd_wen,
    input  logic [REG_AW-1:0] i_wb_rd_waddr,
    output logic [FWD_W-1:0]  o_fwd_c
);

    logic mem_hit_c;
    logic wb_hit_c;

    // A load in EX/MEM has no data yet, so it never forwards from there; x0 never forwards.
    always_comb begin
        mem_hit_c = i_mem_vld && i_mem_rd_wen && !i_mem_mem_read &&
                    (i_mem_rd_waddr != '0) && (i_mem_rd_waddr == i_src_raddr);
        wb_hit_c  = i_wb_vld && i_wb_rd_wen &&
                    (i_wb_rd_waddr != '0) && (i_wb_rd_waddr == i_src_raddr);
        o_fwd_c   = FWD_RF;
        if (mem_hit_c) begin
            o_fwd_c = FWD_EXMEM;
        end else if (wb_hit_c) begin
            o_fwd_c = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use stall, branch flush, memory wait.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [REG_AW-1:0] i_id_rs1_raddr,
    input  logic [REG_AW-1:0] i_id_rs2_raddr,
    input  logic              i_id_rs1_used,
    input  logic              i_id_rs2_used,
    input  logic [REG_AW-1:0] i_ex_rd_waddr,
    input  logic              i_ex_rd_wen,
    input  logic              i_ex_mem_read,
    input  logic              i_ex_vld,
    input  logic [REG_AW-1:0] i_mem_rd_waddr,
    input  logic              i_mem_rd_wen,
    input  logic              i_mem_mem_read,
    input  logic              i_mem_vld,
    input  logic [REG_AW-1:0] i_wb_rd_waddr,
    input  logic              i_wb_rd_wen,
    input  logic              i_wb_vld,
    input  logic              i_branch_taken,
    input  logic              i_dmem_req,
    input  logic              i_dmem_ack,
    output logic              o_stall_if,
    output logic              o_stall_id,
    output logic              o_stall_ex,
    output logic              o_stall_mem,
    output logic              o_flush_id,
    output logic              o_flush_ex,
    output logic [FWD_W-1:0]  o_fwd_a,
    output logic [FWD_W-1:0]  o_fwd_b,
    output logic [1:0]        o_state,
    output logic [CNT_W-1:0]  o_stall_cnt
);

    state_e             state_q;
    state_e             state_d;
    logic [CNT_W-1:0]   stall_cnt_q;
    logic [FWD_W-1:0]   fwd_a_c;
    logic [FWD_W-1:0]   fwd_b_c;
    logic               ld_use_c;
    logic               mwait_c;

    fwd_sel u_fwd_a (
        .i_src_raddr    (i_id_rs1_raddr),
        .i_mem_vld      (i_mem_vld),
        .i_mem_rd_wen   (i_mem_rd_wen),
        .i_mem_mem_read (i_mem_mem_read),
        .i_mem_rd_waddr (i_mem_rd_waddr),
        .i_wb_vld       (i_wb_vld),
        .i_wb_rd_wen    (i_wb_rd_wen),
        .i_wb_rd_waddr  (i_wb_rd_waddr),
        .o_fwd_c        (fwd_a_c)
    );

    fwd_sel u_fwd_b (
        .i_src_raddr    (i_id_rs2_raddr),
        .i_mem_vld      (i_mem_vld),
        .i_mem_rd_wen   (i_mem_rd_wen),
        .i_mem_mem_read (i_mem_mem_read),
        .i_mem_rd_waddr (i_mem_rd_waddr),
        .i_wb_vld       (i_wb_vld),
        .i_wb_rd_wen    (i_wb_rd_wen),
        .i_wb_rd_waddr  (i_wb_rd_waddr),
        .o_fwd_c        (fwd_b_c)
    );

    // Hazard events: load in EX feeding a used ID source (x0 excluded), and an outstanding data access.
    always_comb begin
        ld_use_c = i_ex_vld && i_ex_mem_read && (i_ex_rd_waddr != '0) &&
                   ((i_id_rs1_used && (i_id_rs1_raddr == i_ex_rd_waddr)) ||
                    (i_id_rs2_used && (i_id_rs2_raddr == i_ex_rd_waddr)));
        mwait_c  = i_dmem_req && !i_dmem_ack;
    end

    // State register; reset discards whatever operation was in progress.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and controls; every state re-arbitrates events with priority mwait > branch > load-use.
    always_comb begin
        state_d     = ST_RUN;
        o_stall_if  = 1'b0;
        o_stall_id  = 1'b0;
        o_stall_ex  = 1'b0;
        o_stall_mem = 1'b0;
        o_flush_id  = 1'b0;
        o_flush_ex  = 1'b0;
        o_fwd_a     = FWD_RF;
        o_fwd_b     = FWD_RF;
        if (!i_rst) begin
            o_fwd_a = fwd_a_c;
            o_fwd_b = fwd_b_c;
            if (mwait_c) begin
                o_stall_if  = 1'b1;
                o_stall_id  = 1'b1;
                o_stall_ex  = 1'b1;
                o_stall_mem = 1'b1;
                state_d     = ST_MWAIT;
            end else if (i_branch_taken) begin
                o_flush_id  = 1'b1;
                o_flush_ex  = 1'b1;
                state_d     = ST_FLUSH;
            end else if (ld_use_c) begin
                o_stall_if  = 1'b1;
                o_stall_id  = 1'b1;
                o_flush_ex  = 1'b1;
                state_d     = ST_LDUSE;
            end
        end
    end

    // Saturating count of front-end stall cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_cnt_q <= '0;
        end else if (o_stall_if && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign o_state     = state_q;
    assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
module tb_hazard_ctrl;

    logic        i_clk;
    logic        i_rst;
    logic [4:0]  i_id_rs1_raddr, i_id_rs2_raddr;
    logic        i_id_rs1_used, i_id_rs2_used;
    logic [4:0]  i_ex_rd_waddr;
    logic        i_ex_rd_wen, i_ex_mem_read, i_ex_vld;
    logic [4:0]  i_mem_rd_waddr;
    logic        i_mem_rd_wen, i_mem_mem_read, i_mem_vld;
    logic [4:0]  i_wb_rd_waddr;
    logic        i_wb_rd_wen, i_wb_vld;
    logic        i_branch_taken, i_dmem_req, i_dmem_ack;
    logic        o_stall_if, o_stall_id, o_stall_ex, o_stall_mem;
    logic        o_flush_id, o_flush_ex;
    logic [1:0]  o_fwd_a, o_fwd_b, o_state;
    logic [15:0] o_stall_cnt;

    int errors = 0;
    int checks = 0;

    hazard_ctrl dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_id_rs1_raddr(i_id_rs1_raddr), .i_id_rs2_raddr(i_id_rs2_raddr),
        .i_id_rs1_used(i_id_rs1_used), .i_id_rs2_used(i_id_rs2_used),
        .i_ex_rd_waddr(i_ex_rd_waddr), .i_ex_rd_wen(i_ex_rd_wen),
        .i_ex_mem_read(i_ex_mem_read), .i_ex_vld(i_ex_vld),
        .i_mem_rd_waddr(i_mem_rd_waddr), .i_mem_rd_wen(i_mem_rd_wen),
        .i_mem_mem_read(i_mem_mem_read), .i_mem_vld(i_mem_vld),
        .i_wb_rd_waddr(i_wb_rd_waddr), .i_wb_rd_wen(i_wb_rd_wen), .i_wb_vld(i_wb_vld),
        .i_branch_taken(i_branch_taken), .i_dmem_req(i_dmem_req), .i_dmem_ack(i_dmem_ack),
        .o_stall_if(o_stall_if), .o_stall_id(o_stall_id),
        .o_stall_ex(o_stall_ex), .o_stall_mem(o_stall_mem),
        .o_flush_id(o_flush_id), .o_flush_ex(o_flush_ex),
        .o_fwd_a(o_fwd_a), .o_fwd_b(o_fwd_b),
        .o_state(o_state), .o_stall_cnt(o_stall_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Controls packed as {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex}.
    task automatic chk_ctl(input string tag, input logic [5:0] exp);
        check(tag, 32'({o_stall_if, o_stall_id, o_stall_ex, o_stall_mem, o_flush_id, o_flush_ex}),
              32'(exp));
    endtask

    task automatic chk_fwd(input string tag, input logic [1:0] a, input logic [1:0] b);
        check(tag, 32'({o_fwd_a, o_fwd_b}), 32'({a, b}));
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] st, input logic [15:0] cnt);
        check(tag, 32'({o_state, o_stall_cnt}), 32'({st, cnt}));
    endtask

    task automatic idle();
        i_id_rs1_raddr = 5'd0; i_id_rs2_raddr = 5'd0;
        i_id_rs1_used  = 1'b0; i_id_rs2_used  = 1'b0;
        i_ex_rd_waddr  = 5'd0; i_ex_rd_wen = 1'b0; i_ex_mem_read = 1'b0; i_ex_vld = 1'b0;
        i_mem_rd_waddr = 5'd0; i_mem_rd_wen = 1'b0; i_mem_mem_read = 1'b0; i_mem_vld = 1'b0;
        i_wb_rd_waddr  = 5'd0; i_wb_rd_wen = 1'b0; i_wb_vld = 1'b0;
        i_branch_taken = 1'b0; i_dmem_req = 1'b0; i_dmem_ack = 1'b0;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic ld_use_x7();
        i_ex_vld = 1'b1; i_ex_mem_read = 1'b1; i_ex_rd_wen = 1'b1; i_ex_rd_waddr = 5'd7;
        i_id_rs2_raddr = 5'd7; i_id_rs2_used = 1'b1;
    endtask

    initial begin
        // Reset with every kind of event presented: outputs must all be zero.
        idle();
        i_rst = 1'b1;
        ld_use_x7();
        i_branch_taken = 1'b1; i_dmem_req = 1'b1;
        i_mem_vld = 1'b1; i_mem_rd_wen = 1'b1; i_mem_rd_waddr = 5'd5; i_id_rs1_raddr = 5'd5;
        settle();
        chk_ctl("rst_ctl", 6'b000000);
        chk_fwd("rst_fwd", 2'b00, 2'b00);
        tick();
        chk_reg("rst_reg", 2'b00, 16'd0);
        i_rst = 1'b0;
        idle();
        tick();

        // Forwarding: EX/MEM only, EX/MEM+WB, WB only, EX/MEM load skipped.
        i_mem_vld = 1'b1; i_mem_rd_wen = 1'b1; i_mem_rd_waddr = 5'd5;
        i_id_rs1_raddr = 5'd5; i_id_rs2_raddr = 5'd3;
        settle();
        chk_fwd("fwd_exmem", 2'b01, 2'b00);
        i_wb_vld = 1'b1; i_wb_rd_wen = 1'b1; i_wb_rd_waddr = 5'd5; i_id_rs2_raddr = 5'd5;
        settle();
        chk_fwd("fwd_exmem_over_wb", 2'b01, 2'b01);
        i_mem_vld = 1'b0;
        settle();
        chk_fwd("fwd_wb_only", 2'b10, 2'b10);
        i_mem_vld = 1'b1; i_mem_mem_read = 1'b1;
        settle();
        chk_fwd("fwd_mem_load_skipped", 2'b10, 2'b10);
        chk_ctl("fwd_no_stall", 6'b000000);
        idle();

        // Load-use on rs2=x7: one stall cycle, LDUSE then RUN.
        ld_use_x7();
        i_id_rs2_used = 1'b0;
        settle();
        chk_ctl("lu_unused_src", 6'b000000);
        i_id_rs2_used = 1'b1;
        settle();
        chk_ctl("lu_ctl", 6'b110001);
        tick();
        chk_reg("lu_state", 2'b01, 16'd1);
        idle();
        settle();
        chk_ctl("lu_release", 6'b000000);
        tick();
        chk_reg("lu_back_run", 2'b00, 16'd1);

        // Load-use with branch: flush wins, no stall.
        ld_use_x7();
        i_branch_taken = 1'b1;
        settle();
        chk_ctl("br_ctl", 6'b000011);
        tick();
        chk_reg("br_state", 2'b11, 16'd1);
        idle();
        tick();
        chk_reg("br_back_run", 2'b00, 16'd1);

        // Memory wait three cycles with a pending branch, then ack.
        i_dmem_req = 1'b1; i_branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk_ctl("mw_ctl", 6'b111100);
            tick();
            chk_reg("mw_state", 2'b10, 16'(i + 2));
        end
        i_dmem_ack = 1'b1;
        settle();
        chk_ctl("mw_ack_ctl", 6'b000011);
        tick();
        chk_reg("mw_ack_state", 2'b11, 16'd4);
        idle();
        tick();
        chk_reg("mw_back_run", 2'b00, 16'd4);

        // x0 as load destination and WB destination never forwards or stalls.
        i_ex_vld = 1'b1; i_ex_mem_read = 1'b1; i_ex_rd_wen = 1'b1; i_ex_rd_waddr = 5'd0;
        i_wb_vld = 1'b1; i_wb_rd_wen = 1'b1; i_wb_rd_waddr = 5'd0;
        i_mem_vld = 1'b1; i_mem_rd_wen = 1'b1; i_mem_rd_waddr = 5'd0;
        i_id_rs1_raddr = 5'd0; i_id_rs1_used = 1'b1;
        settle();
        chk_fwd("x0_fwd", 2'b00, 2'b00);
        chk_ctl("x0_ctl", 6'b000000);
        idle();

        // Back-to-back load-use re-stalls.
        ld_use_x7();
        tick();
        chk_reg("lu2_first", 2'b01, 16'd5);
        settle();
        chk_ctl("lu2_ctl", 6'b110001);
        tick();
        chk_reg("lu2_second", 2'b01, 16'd6);
        idle();
        tick();

        // Long memory wait drives the counter into saturation.
        i_dmem_req = 1'b1;
        for (int i = 0; i < 65528; i++) begin
            @(posedge i_clk);
        end
        #1;
        chk_reg("sat_near", 2'b10, 16'hFFFE);
        tick();
        chk_reg("sat_reach", 2'b10, 16'hFFFF);
        tick();
        tick();
        tick();
        chk_reg("sat_hold", 2'b10, 16'hFFFF);
        chk_ctl("sat_still_stall", 6'b111100);

        // Reset in the middle of the wait aborts it.
        i_rst = 1'b1;
        settle();
        chk_ctl("rst_mw_ctl", 6'b000000);
        tick();
        chk_reg("rst_mw_reg", 2'b00, 16'd0);
        i_rst = 1'b0;
        idle();
        tick();
        chk_reg("post_rst_idle", 2'b00, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
